// File: rtl/t2mi_timestamp_extractor.sv
// T2-MI timestamp extractor: parses the byte-serial T2-MI stream, validates the
// 0x20 timestamp packet with CRC-32/MPEG-2 and presents the time fields to the PPS generator.
module t2mi_timestamp_extractor #(
    parameter bit          CHECK_CRC      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        t2mi_valid,
    input  logic [7:0]  t2mi_data,
    input  logic        t2mi_sync,
    output logic        timestamp_valid,
    output logic        timestamp_ready,
    output logic [39:0] seconds_since_2000,
    output logic [31:0] subseconds,
    output logic [12:0] utco,
    output logic [3:0]  bandwidth_code,
    output logic [7:0]  packet_count,
    output logic        crc_error,
    output logic        format_error,
    output logic [2:0]  dbg_state
);

    // Input handshake: valid-only stream with no back-pressure. A byte is taken on
    // every rising clk edge where t2mi_valid is high; t2mi_sync means nothing unless
    // t2mi_valid is also high, and then marks byte 0 of a packet.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CRC     = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [15:0] TS_LEN   = 16'h0058;
    localparam logic [7:0]  TS_TYPE  = 8'h20;
    localparam int          GW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [3:0]      r_idx;
    logic [31:0]     r_crc;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_len_hi;
    logic [7:0]      r_cnt;
    logic [83:0]     r_stage;
    logic            r_commit;
    logic            r_reject;

    logic            w_sync;
    logic            w_in_pkt;
    logic            w_timeout;
    logic [31:0]     w_crc_seed;
    logic [31:0]     w_crc_next;
    logic            w_len_ok;
    logic            w_crc_good;

    // MSB-first, non-reflected CRC over one byte (eight bit-steps).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    assign w_sync     = t2mi_valid & t2mi_sync;
    assign w_in_pkt   = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_CRC);
    assign w_timeout  = !t2mi_valid && w_in_pkt && (r_gap == GAP_MAX);
    assign w_crc_seed = w_sync ? CRC_INIT : r_crc;
    assign w_crc_next = crc_byte(w_crc_seed, t2mi_data);
    assign w_len_ok   = ({r_len_hi, t2mi_data} == TS_LEN);
    assign w_crc_good = (w_crc_next == 32'h0) || !CHECK_CRC;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_idx              <= 4'd0;
            r_crc              <= CRC_INIT;
            r_gap              <= '0;
            r_len_hi           <= 8'h00;
            r_cnt              <= 8'h00;
            r_stage            <= '0;
            r_commit           <= 1'b0;
            r_reject           <= 1'b0;
            timestamp_valid    <= 1'b0;
            timestamp_ready    <= 1'b0;
            seconds_since_2000 <= 40'h0;
            subseconds         <= 32'h0;
            utco               <= 13'h0;
            bandwidth_code     <= 4'h0;
            packet_count       <= 8'h00;
            crc_error          <= 1'b0;
            format_error       <= 1'b0;
        end else begin
            timestamp_valid <= 1'b0;
            crc_error       <= 1'b0;
            format_error    <= 1'b0;
            r_commit        <= 1'b0;
            r_reject        <= 1'b0;

            // Verdict from the last CRC byte lands one edge later; the next packet
            // cannot touch staging or count before then.
            if (r_commit) begin
                timestamp_valid    <= 1'b1;
                timestamp_ready    <= 1'b1;
                bandwidth_code     <= r_stage[83:80];
                seconds_since_2000 <= r_stage[79:40];
                subseconds         <= {r_stage[39:13], 5'b0};
                utco               <= r_stage[12:0];
                packet_count       <= r_cnt;
            end
            if (r_reject) begin
                crc_error <= 1'b1;
            end

            if (t2mi_valid || !w_in_pkt) begin
                r_gap <= '0;
            end else if (!w_timeout) begin
                r_gap <= r_gap + GW'(1);
            end

            if (w_sync) begin
                // Any sync starts a new packet; inside a packet it also aborts the old one.
                r_crc <= w_crc_next;
                r_idx <= 4'd1;
                if (w_in_pkt) begin
                    format_error <= 1'b1;
                end
                r_state <= (t2mi_data == TS_TYPE) ? S_HEADER : S_SKIP;
            end else if (w_timeout) begin
                format_error <= 1'b1;
                r_state      <= S_IDLE;
            end else if (t2mi_valid) begin
                case (r_state)
                    S_HEADER: begin
                        r_crc <= w_crc_next;
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'd1) begin
                            r_cnt <= t2mi_data;
                        end
                        if (r_idx == 4'd4) begin
                            r_len_hi <= t2mi_data;
                        end
                        if (r_idx == 4'd5) begin
                            r_idx <= 4'd0;
                            if (w_len_ok) begin
                                r_state <= S_PAYLOAD;
                            end else begin
                                format_error <= 1'b1;
                                r_state      <= S_SKIP;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        // The 4 rfu bits of the first payload byte fall off the top.
                        r_crc   <= w_crc_next;
                        r_stage <= {r_stage[75:0], t2mi_data};
                        r_idx   <= r_idx + 4'd1;
                        if (r_idx == 4'd10) begin
                            r_idx   <= 4'd0;
                            r_state <= S_CRC;
                        end
                    end
                    S_CRC: begin
                        r_crc <= w_crc_next;
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'd3) begin
                            r_idx   <= 4'd0;
                            r_state <= S_IDLE;
                            if (w_crc_good) begin
                                r_commit <= 1'b1;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t2mi_timestamp_extractor.sv
// Bench for t2mi_timestamp_extractor: drives one stream into a CRC-checking and a
// non-checking instance and compares both against a packet-level reference model.
module tb_t2mi_timestamp_extractor;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic t2mi_valid = 1'b0;
    logic t2mi_sync = 1'b0;
    logic [7:0] t2mi_data = 8'h00;

    // index 0: CHECK_CRC=1, index 1: CHECK_CRC=0
    logic [1:0]        o_tsv, o_rdy, o_ce, o_fe;
    logic [1:0][39:0]  o_sec;
    logic [1:0][31:0]  o_sub;
    logic [1:0][12:0]  o_utco;
    logic [1:0][3:0]   o_bw;
    logic [1:0][7:0]   o_pc;
    logic [1:0][2:0]   o_st;

    t2mi_timestamp_extractor #(.CHECK_CRC(1'b1), .TIMEOUT_CYCLES(TO)) u_chk (
        .clk(clk), .rst_n(rst_n), .t2mi_valid(t2mi_valid), .t2mi_data(t2mi_data),
        .t2mi_sync(t2mi_sync), .timestamp_valid(o_tsv[0]), .timestamp_ready(o_rdy[0]),
        .seconds_since_2000(o_sec[0]), .subseconds(o_sub[0]), .utco(o_utco[0]),
        .bandwidth_code(o_bw[0]), .packet_count(o_pc[0]), .crc_error(o_ce[0]),
        .format_error(o_fe[0]), .dbg_state(o_st[0])
    );

    t2mi_timestamp_extractor #(.CHECK_CRC(1'b0), .TIMEOUT_CYCLES(TO)) u_nochk (
        .clk(clk), .rst_n(rst_n), .t2mi_valid(t2mi_valid), .t2mi_data(t2mi_data),
        .t2mi_sync(t2mi_sync), .timestamp_valid(o_tsv[1]), .timestamp_ready(o_rdy[1]),
        .seconds_since_2000(o_sec[1]), .subseconds(o_sub[1]), .utco(o_utco[1]),
        .bandwidth_code(o_bw[1]), .packet_count(o_pc[1]), .crc_error(o_ce[1]),
        .format_error(o_fe[1]), .dbg_state(o_st[1])
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tv_cnt[2] = '{0, 0};
    int ce_cnt[2] = '{0, 0};
    int fe_cnt[2] = '{0, 0};
    int tv_cyc[2] = '{0, 0};
    int fe_cyc[2] = '{0, 0};
    int snap_tv[2], snap_ce[2], snap_fe[2];
    int acc_cyc[21];

    logic [7:0]  pkt [21];
    logic [39:0] exp_sec[2];
    logic [31:0] exp_sub[2];
    logic [12:0] exp_utco[2];
    logic [3:0]  exp_bw[2];
    logic [7:0]  exp_pc[2];
    logic        exp_rdy[2];

    always @(posedge clk) cyc++;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (o_tsv[d] === 1'b1) begin tv_cnt[d]++; tv_cyc[d] = cyc; end
            if (o_ce[d] === 1'b1)  ce_cnt[d]++;
            if (o_fe[d] === 1'b1)  begin fe_cnt[d]++; fe_cyc[d] = cyc; end
            if (o_ce[d] === 1'b1 || o_fe[d] === 1'b1)
                cmp($sformatf("d%0d ce_fe_exclusive", d), 64'(o_ce[d] & o_fe[d]), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ pkt[i][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
            end
        return c;
    endfunction

    function automatic logic [87:0] mk(input logic [3:0] rfu, input logic [3:0] bw,
                                       input logic [39:0] sec, input logic [26:0] s27,
                                       input logic [12:0] ut);
        return {rfu, bw, sec, s27, ut};
    endfunction

    function automatic logic [87:0] sent_payload();
        logic [87:0] p;
        p = '0;
        for (int i = 0; i < 11; i++) p = {p[79:0], pkt[6+i]};
        return p;
    endfunction

    task automatic build(input logic [7:0] typ, input logic [7:0] cnt,
                         input logic [15:0] len, input logic [87:0] pl);
        logic [31:0] c;
        pkt[0] = typ;
        pkt[1] = cnt;
        pkt[2] = 8'($urandom_range(0, 255));
        pkt[3] = 8'($urandom_range(0, 255));
        pkt[4] = len[15:8];
        pkt[5] = len[7:0];
        for (int i = 0; i < 11; i++) pkt[6+i] = pl[87-8*i -: 8];
        c = crc32(17);
        pkt[17] = c[31:24];
        pkt[18] = c[23:16];
        pkt[19] = c[15:8];
        pkt[20] = c[7:0];
    endtask

    task automatic flip(input int pos);
        int idx;
        idx = 6 + (87 - pos) / 8;
        pkt[idx][pos % 8] = ~pkt[idx][pos % 8];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_sec[d] = '0; exp_sub[d] = '0; exp_utco[d] = '0;
            exp_bw[d] = '0; exp_pc[d] = '0; exp_rdy[d] = 1'b0;
        end
    endtask

    task automatic model_accept(input int d);
        logic [87:0] p;
        p = sent_payload();
        exp_bw[d]   = p[83:80];
        exp_sec[d]  = p[79:40];
        exp_sub[d]  = {p[39:13], 5'b0};
        exp_utco[d] = p[12:0];
        exp_pc[d]   = pkt[1];
        exp_rdy[d]  = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t2mi_valid = 1'b0;
            t2mi_sync  = 1'b0;
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic s, output int acc);
        @(negedge clk);
        t2mi_valid = 1'b1;
        t2mi_data  = b;
        t2mi_sync  = s;
        acc = cyc + 1;
    endtask

    task automatic send_bytes(input int first, input int n);
        int a;
        for (int i = first; i < first + n; i++) begin
            idle($urandom_range(0, 2));
            drive(pkt[i], (i == 0), a);
            acc_cyc[i] = a;
        end
    endtask

    task automatic snapshot();
        for (int d = 0; d < 2; d++) begin
            snap_tv[d] = tv_cnt[d]; snap_ce[d] = ce_cnt[d]; snap_fe[d] = fe_cnt[d];
        end
    endtask

    task automatic check_outputs(input string step);
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("%s d%0d seconds", step, d), 64'(o_sec[d]), 64'(exp_sec[d]));
            cmp($sformatf("%s d%0d subseconds", step, d), 64'(o_sub[d]), 64'(exp_sub[d]));
            cmp($sformatf("%s d%0d utco", step, d), 64'(o_utco[d]), 64'(exp_utco[d]));
            cmp($sformatf("%s d%0d bw", step, d), 64'(o_bw[d]), 64'(exp_bw[d]));
            cmp($sformatf("%s d%0d pkt_count", step, d), 64'(o_pc[d]), 64'(exp_pc[d]));
            cmp($sformatf("%s d%0d ready", step, d), 64'(o_rdy[d]), 64'(exp_rdy[d]));
        end
    endtask

    task automatic check_pkt(input string step, input bit good0, input bit good1,
                             input bit ce0, input int fe_exp, input int last_acc,
                             input int fe_at);
        bit good;
        for (int d = 0; d < 2; d++) begin
            good = (d == 0) ? good0 : good1;
            cmp($sformatf("%s d%0d tv_pulses", step, d), 64'(tv_cnt[d] - snap_tv[d]), 64'(good));
            if (good)
                cmp($sformatf("%s d%0d tv_latency", step, d), 64'(tv_cyc[d]), 64'(last_acc + 1));
            cmp($sformatf("%s d%0d crc_err_pulses", step, d), 64'(ce_cnt[d] - snap_ce[d]),
                64'((d == 0) ? ce0 : 1'b0));
            cmp($sformatf("%s d%0d fmt_err_pulses", step, d), 64'(fe_cnt[d] - snap_fe[d]), 64'(fe_exp));
            if (fe_at >= 0)
                cmp($sformatf("%s d%0d fmt_err_cycle", step, d), 64'(fe_cyc[d]), 64'(fe_at));
        end
        check_outputs(step);
    endtask

    // Sends the current 21-byte packet and derives every expectation from its bytes.
    task automatic run_pkt(input string step);
        bit ts_type, len_ok, crc_ok;
        int fe_at;
        ts_type = (pkt[0] == 8'h20);
        len_ok  = ({pkt[4], pkt[5]} == 16'h0058);
        crc_ok  = (crc32(21) == 32'h0);
        snapshot();
        send_bytes(0, 21);
        idle(5);
        if (ts_type && len_ok && crc_ok) model_accept(0);
        if (ts_type && len_ok) model_accept(1);
        fe_at = (ts_type && !len_ok) ? acc_cyc[5] : -1;
        check_pkt(step, ts_type && len_ok && crc_ok, ts_type && len_ok,
                  ts_type && len_ok && !crc_ok, (ts_type && !len_ok) ? 1 : 0,
                  acc_cyc[20], fe_at);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int a, last, fe_at;
        logic [63:0] r64;
        logic [87:0] pl;
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("reset d%0d tv", d), 64'(o_tsv[d]), 64'd0);
            cmp($sformatf("reset d%0d ce", d), 64'(o_ce[d]), 64'd0);
            cmp($sformatf("reset d%0d fe", d), 64'(o_fe[d]), 64'd0);
        end
        check_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        build(8'h20, 8'h07, 16'h0058, mk(4'h0, 4'h2, 40'd1000, 27'h4000000, 13'd18));
        run_pkt("good");
        cmp("good abs seconds", 64'(o_sec[0]), 64'h3E8);
        cmp("good abs subseconds", 64'(o_sub[0]), 64'h8000_0000);
        cmp("good abs utco", 64'(o_utco[0]), 64'd18);
        cmp("good abs bw", 64'(o_bw[0]), 64'd2);
        cmp("good abs count", 64'(o_pc[0]), 64'h07);
        cmp("good abs ready", 64'(o_rdy[0]), 64'd1);

        build(8'h20, 8'h08, 16'h0058, mk(4'h0, 4'h2, 40'd1000, 27'h4000000, 13'd18));
        flip(50);
        run_pkt("bitflip");

        snapshot();
        drive(8'h00, 1'b1, a);
        for (int i = 1; i < 200; i++) drive(8'($urandom_range(0, 255)), 1'b0, a);
        idle(5);
        check_pkt("baseband", 1'b0, 1'b0, 1'b0, 0, 0, -1);
        build(8'h20, 8'h09, 16'h0058, mk(4'h0, 4'h3, 40'd1005, 27'h0008000, 13'd18));
        run_pkt("after_bb");
        cmp("after_bb abs subseconds", 64'(o_sub[0]), 64'h0010_0000);
        cmp("after_bb abs seconds", 64'(o_sec[0]), 64'd1005);

        build(8'h20, 8'h0A, 16'h0050, mk(4'h0, 4'h1, 40'd2000, 27'h1, 13'd5));
        run_pkt("badlen");
        build(8'h20, 8'h0B, 16'h0058, mk(4'h0, 4'h1, 40'd2001, 27'h2, 13'd6));
        run_pkt("after_badlen");

        snapshot();
        build(8'h20, 8'h0C, 16'h0058, mk(4'h0, 4'h1, 40'd3000, 27'h3, 13'd7));
        send_bytes(0, 10);
        build(8'h20, 8'h0D, 16'h0058, mk(4'h0, 4'h4, 40'd4605, 27'h123456, 13'd37));
        send_bytes(0, 21);
        idle(5);
        model_accept(0);
        model_accept(1);
        check_pkt("presync", 1'b1, 1'b1, 1'b0, 1, acc_cyc[20], acc_cyc[0]);
        cmp("presync abs seconds", 64'(o_sec[0]), 64'd4605);

        snapshot();
        build(8'h20, 8'h0E, 16'h0058, mk(4'h0, 4'h5, 40'd5000, 27'h55, 13'd9));
        send_bytes(0, 19);
        last = acc_cyc[18];
        idle(TO + 5);
        fe_at = last + TO;
        send_bytes(19, 2);
        idle(5);
        check_pkt("timeout", 1'b0, 1'b0, 1'b0, 1, 0, fe_at);

        for (int it = 0; it < 20; it++) begin
            r64 = {$urandom, $urandom};
            pl = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    (it == 2) ? 40'hFF_FFFF_FFFF : r64[39:0],
                    27'($urandom), 13'($urandom));
            build((it % 7 == 3) ? 8'h11 : 8'h20, 8'($urandom_range(0, 255)),
                  (it % 5 == 4) ? (16'h0100 | 16'(it)) : 16'h0058, pl);
            if ($urandom_range(0, 2) == 0) flip($urandom_range(0, 87));
            run_pkt($sformatf("rand%0d", it));
        end

        build(8'h20, 8'h0F, 16'h0058, mk(4'h0, 4'h6, 40'd6000, 27'h66, 13'd11));
        send_bytes(0, 10);
        @(negedge clk);
        t2mi_valid = 1'b0;
        t2mi_sync  = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("midrst d%0d tv", d), 64'(o_tsv[d]), 64'd0);
            cmp($sformatf("midrst d%0d ce", d), 64'(o_ce[d]), 64'd0);
            cmp($sformatf("midrst d%0d fe", d), 64'(o_fe[d]), 64'd0);
        end
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        build(8'h20, 8'h10, 16'h0058, mk(4'h0, 4'h7, 40'd7000, 27'h77, 13'd12));
        run_pkt("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/t2mi_timestamp_extractor.md
Name: t2mi_timestamp_extractor

Overview:
- Parses the byte-serial T2-MI packet stream and extracts the DVB-T2 timestamp packet (packet_type 0x20).
- After CRC-32 validation, presents seconds_since_2000 / subseconds to the downstream pps_generator as a one-cycle timestamp_valid strobe.
- Sits between the TS/T2-MI depacketiser and pps_generator.
- Rejects malformed or corrupted packets and flags them; held outputs are never disturbed by bad packets.

Parameters:
- CHECK_CRC, 1, 1 = discard packets failing CRC-32/MPEG-2; 0 = accept without check (crc_error never pulses).
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between accepted bytes inside a packet before abort (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- t2mi_valid  in  1  byte strobe; t2mi_data is sampled only when high
- t2mi_data  in  8  packet byte
- t2mi_sync  in  1  qualified by t2mi_valid; marks byte 0 (packet_type) of a packet
- timestamp_valid  out  1  one-cycle pulse: new timestamp on outputs
- timestamp_ready  out  1  sticky; high once the first good timestamp has been captured since reset
- seconds_since_2000  out  40  held seconds field
- subseconds  out  32  binary fraction of a second: {subsec27, 5'b0}
- utco  out  13  UTC offset field
- bandwidth_code  out  4  bw field
- packet_count  out  8  packet_count byte of the last good timestamp packet
- crc_error  out  1  one-cycle pulse on CRC mismatch
- format_error  out  1  one-cycle pulse on length error, premature sync, or timeout

Behaviour:
- Reset: all outputs 0; FSM in IDLE; CRC register = 0xFFFFFFFF; counters cleared.
- Packet layout, byte order MSB first:
  - header, 6 bytes: type, count, 2 bytes superframe/rfu, 2 bytes payload_len in bits
  - payload, 11 bytes: rfu[3:0]|bw[3:0], seconds[39:0], then subsec[26:0] followed by utco[12:0]
  - CRC, 4 bytes
- FSM states: IDLE, HEADER, PAYLOAD, CRC, SKIP.
  - IDLE: wait for valid & sync. On that byte: if type == 0x20, go to HEADER with byte index 1; otherwise go to SKIP.
  - HEADER: collect bytes 1..5. At byte 5: if payload_len == 16'h0058 (88 bits), go to PAYLOAD; otherwise pulse format_error and go to SKIP.
  - PAYLOAD: shift 11 bytes into an 88-bit staging register, then go to CRC.
  - CRC: take 4 bytes. On the last byte, evaluate:
    - residue == 0, or CHECK_CRC == 0: load all output registers from staging, pulse timestamp_valid, set timestamp_ready.
    - otherwise: pulse crc_error; outputs unchanged.
    - Either way, return to IDLE.
  - SKIP: ignore bytes until the next valid & sync, which is handled exactly as in IDLE (same cycle).
- CRC computation:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
  - Computed bytewise (8 bit-steps combinationally per byte) over all 21 bytes; a good packet leaves residue 0.
  - Re-initialised on every sync byte.
- Latency: timestamp_valid, and the updated outputs, appear on the clock edge after the edge that accepted the last CRC byte.
- Output registers change only on a good packet; they are held otherwise.
- Premature sync: valid & sync while in HEADER, PAYLOAD or CRC.
  - Pulse format_error.
  - Abort the current packet.
  - Treat that byte as byte 0 of a new packet, same cycle.
- Timeout: gap counter is cleared on each accepted byte and counts while in HEADER, PAYLOAD or CRC. On reaching TIMEOUT_CYCLES-1: pulse format_error, go to IDLE.
- Simultaneous events: crc_error and format_error never pulse in the same cycle. A premature sync takes priority over timeout.
- Reset mid-packet: immediate return to reset state; timestamp_ready is cleared.
- Field arithmetic: no range check on seconds; 40'hFFFFFFFFFF passes through unchanged. Subseconds LSBs [4:0] are always 0.

Test Plan:
- Good packet: count=0x07, bw=0x2, seconds=40'd1000, subsec27=27'h4000000, utco=13'd18, valid CRC → one timestamp_valid pulse 1 cycle after last CRC byte; seconds=0x00000003E8, subseconds=0x80000000, utco=18, bandwidth_code=2, packet_count=0x07, timestamp_ready=1.
- Same packet with one payload bit flipped → crc_error pulse, no timestamp_valid, outputs hold previous values. Repeat with CHECK_CRC=0 → timestamp_valid, no crc_error.
- Type 0x00 baseband packet of 200 bytes, then a good timestamp packet with seconds=1005, subsec27=27'h0008000 → no output during the baseband packet; then seconds=1005, subseconds=0x00100000.
- payload_len=0x0050 → format_error pulse at header byte 5; the following good packet is still decoded.
- Sync asserted at payload byte 4 → format_error pulse; the new packet starting on that byte (good, seconds=4605) decodes correctly.
- Gap of TIMEOUT_CYCLES cycles inside the CRC bytes → format_error pulse, no timestamp_valid. Assert rst_n low mid-payload → all outputs 0, timestamp_ready=0.
